xy_route_stage: RTL and testbench

- Registered, parametrised successor to the combinational XY router decode.
- Buffers incoming flit headers (destination X/Y plus payload tag) in a small FIFO.
- Computes the dimension-ordered output port against this node's coordinates, selectable XY or YX, and presents a one-hot port request through a registered valid/ready output stage.
- Sits between the router input link and the switch allocator.

---
 rtl/xy_route_stage.sv | 114 +++++++++++
 tb/tb_xy_route_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/xy_route_stage.sv
// Registered dimension-ordered route stage: a header FIFO feeding a single
// output register that carries the one-hot port request toward the switch allocator.
module xy_route_stage #(
    parameter int COORD_W   = 30,
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [COORD_W-1:0]         cur_x,
    input  logic [COORD_W-1:0]         cur_y,
    input  logic                       mode_yx,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COORD_W-1:0]         in_dest_x,
    input  logic [COORD_W-1:0]         in_dest_y,
    input  logic [PAYLOAD_W-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_port,
    output logic [PAYLOAD_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0]     fill
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam int HW = 2 * COORD_W + PAYLOAD_W;
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    localparam logic [4:0] P_LOCAL = 5'b00001;
    localparam logic [4:0] P_EAST  = 5'b00010;
    localparam logic [4:0] P_WEST  = 5'b00100;
    localparam logic [4:0] P_NORTH = 5'b01000;
    localparam logic [4:0] P_SOUTH = 5'b10000;

    logic [HW-1:0]        mem_q [DEPTH];
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [FW-1:0]        fill_q, fill_d;
    logic                 out_valid_q, out_valid_d;
    logic [4:0]           out_port_q, out_port_d;
    logic [PAYLOAD_W-1:0] out_tag_q, out_tag_d;

    logic                 push, load;
    logic [COORD_W-1:0]   head_x, head_y;
    logic [PAYLOAD_W-1:0] head_tag;

    function automatic logic [4:0] route(
        input logic [COORD_W-1:0] dx, dy, cx, cy,
        input logic               yx
    );
        logic [4:0] xp, yp;
        xp = (dx > cx) ? P_EAST  : (dx < cx) ? P_WEST  : 5'b0;
        yp = (dy > cy) ? P_NORTH : (dy < cy) ? P_SOUTH : 5'b0;
        if (yx)
            return (yp != 5'b0) ? yp : (xp != 5'b0) ? xp : P_LOCAL;
        else
            return (xp != 5'b0) ? xp : (yp != 5'b0) ? yp : P_LOCAL;
    endfunction

    // Ready depends only on registered occupancy, so a pop never opens a
    // slot for a push in the same cycle.
    assign in_ready = (fill_q != FULL);
    assign push     = in_valid && in_ready;
    assign load     = (fill_q != '0) && (!out_valid_q || out_ready);

    assign {head_x, head_y, head_tag} = mem_q[rptr_q];

    always_comb begin
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_port_d  = out_port_q;
        out_tag_d   = out_tag_q;
        if (push && !load)
            fill_d = fill_q + FW'(1);
        else if (!push && load)
            fill_d = fill_q - FW'(1);
        if (load) begin
            out_valid_d = 1'b1;
            out_port_d  = route(head_x, head_y, cur_x, cur_y, mode_yx);
            out_tag_d   = head_tag;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_port_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (load) rptr_q <= rptr_q + PW'(1);
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_port_q  <= out_port_d;
            out_tag_q   <= out_tag_d;
        end
    end

    // Storage needs no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {in_dest_x, in_dest_y, in_tag};
    end

    assign out_valid = out_valid_q;
    assign out_port  = out_port_q;
    assign out_tag   = out_tag_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_xy_route_stage.sv
// Directed bench for xy_route_stage: reset, XY/YX ordering, backpressure,
// full-width unsigned compares and mid-stream reset.
module tb_xy_route_stage;

    localparam int COORD_W   = 30;
    localparam int DEPTH     = 4;
    localparam int PAYLOAD_W = 8;

    logic                   clk, rst;
    logic [COORD_W-1:0]     cur_x, cur_y;
    logic                   mode_yx;
    logic                   in_valid, in_ready;
    logic [COORD_W-1:0]     in_dest_x, in_dest_y;
    logic [PAYLOAD_W-1:0]   in_tag;
    logic                   out_valid, out_ready;
    logic [4:0]             out_port;
    logic [PAYLOAD_W-1:0]   out_tag;
    logic [$clog2(DEPTH):0] fill;

    int n_assert = 0;
    int n_fail   = 0;

    xy_route_stage #(.COORD_W(COORD_W), .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y), .mode_yx(mode_yx),
        .in_valid(in_valid), .in_ready(in_ready), .in_dest_x(in_dest_x),
        .in_dest_y(in_dest_y), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_port(out_port), .out_tag(out_tag), .fill(fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int dx, input int dy, input int tg);
        in_valid  = v;
        in_dest_x = COORD_W'(dx);
        in_dest_y = COORD_W'(dy);
        in_tag    = PAYLOAD_W'(tg);
    endtask

    task automatic chk_out(input string tag, input logic [4:0] port, input int tg);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".port"},  64'(out_port),  64'(port));
        chk({tag, ".tag"},   64'(out_tag),   64'(tg));
    endtask

    int         xy_dx [5] = '{9, 2, 5, 5, 5};
    int         xy_dy [5] = '{1, 9, 9, 0, 5};
    logic [4:0] xy_p  [5] = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
    int         bp_dx [6] = '{9, 1, 5, 5, 5, 6};
    int         bp_dy [6] = '{5, 5, 8, 2, 5, 0};
    logic [4:0] bp_p  [6] = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01, 5'h02};

    initial begin
        rst = 1'b0; mode_yx = 1'b0; out_ready = 1'b1;
        cur_x = COORD_W'(5); cur_y = COORD_W'(5);
        drive(1'b0, 0, 0, 0);

        // reset pulse mid-cycle, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.fill",      64'(fill),      64'd0);
        chk("rst.out_port",  64'(out_port),  64'd0);
        chk("rst.out_tag",   64'(out_tag),   64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle.out_valid", 64'(out_valid), 64'd0);

        // XY basic: one header per cycle, first result two edges after first push
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, xy_dx[i], xy_dy[i], i + 1);
            tick();
            if (i == 0) chk("xy.lat_not_yet", 64'(out_valid), 64'd0);
            else begin
                chk_out($sformatf("xy%0d", i - 1), xy_p[i-1], i);
                chk($sformatf("xy%0d.fill", i - 1), 64'(fill), 64'd1);
            end
        end
        drive(1'b0, 0, 0, 0);
        tick();
        chk_out("xy4", xy_p[4], 5);
        tick();
        chk("xy.drained", 64'(out_valid), 64'd0);

        // YX order
        mode_yx = 1'b1;
        drive(1'b1, 9, 1, 6); tick();
        drive(1'b0, 0, 0, 0); tick();
        chk_out("yx.south", 5'h10, 6);
        drive(1'b1, 9, 5, 7); tick();
        drive(1'b0, 0, 0, 0); tick();
        chk_out("yx.east", 5'h02, 7);
        tick();
        chk("yx.drained", 64'(out_valid), 64'd0);
        mode_yx = 1'b0;

        // Backpressure: h0 to output register, h1..h4 fill the FIFO, h5 held
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bp_dx[i], bp_dy[i], 16 + i);
            tick();
        end
        chk("bp.fill4", 64'(fill), 64'd4);
        chk("bp.in_ready0", 64'(in_ready), 64'd0);
        drive(1'b1, bp_dx[5], bp_dy[5], 21);
        tick();
        chk("bp.fill_held", 64'(fill), 64'd4);
        chk_out("bp.hold0", bp_p[0], 16);
        tick();
        chk_out("bp.hold1", bp_p[0], 16);
        chk("bp.in_ready_still0", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk_out("bp.h1", bp_p[1], 17);
        chk("bp.fill3", 64'(fill), 64'd3);
        chk("bp.in_ready_back", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 0, 0, 0);
        chk_out("bp.h2", bp_p[2], 18);
        chk("bp.fill3b", 64'(fill), 64'd3);
        for (int i = 3; i < 6; i++) begin
            tick();
            chk_out($sformatf("bp.h%0d", i), bp_p[i], 16 + i);
            chk($sformatf("bp.fill_h%0d", i), 64'(fill), 64'(5 - i));
        end
        tick();
        chk("bp.drained", 64'(out_valid), 64'd0);

        // Extremes: full-width unsigned compares
        cur_x = COORD_W'(32'h3FFF_FFFF); cur_y = '0;
        drive(1'b1, 0, 32'h3FFF_FFFF, 30); tick();
        drive(1'b0, 0, 0, 0); tick();
        chk_out("ext.xy_west", 5'h04, 30);
        mode_yx = 1'b1;
        drive(1'b1, 0, 32'h3FFF_FFFF, 31); tick();
        drive(1'b0, 0, 0, 0); tick();
        chk_out("ext.yx_north", 5'h08, 31);
        mode_yx = 1'b0;
        cur_x = COORD_W'(5); cur_y = COORD_W'(5);
        tick();

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9, 5, 40 + i);
            tick();
        end
        drive(1'b0, 0, 0, 0);
        chk("mid.fill_pre", 64'(fill), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid.fill", 64'(fill), 64'd0);
        chk("mid.out_valid", 64'(out_valid), 64'd0);
        chk("mid.in_ready", 64'(in_ready), 64'd1);
        chk("mid.out_port", 64'(out_port), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mid.no_stale%0d", i), 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
